// File: rtl/av_snapshot_regs_if.sv
// av_snapshot_regs_if: Avalon-MM slave bus bundle for the snapshot register bank.
interface av_snapshot_regs_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    modport master(output address, read, write, writedata, input readdata);
    modport slave(input address, read, write, writedata, output readdata);
endinterface

// File: rtl/av_snapshot_regs.sv
// av_snapshot_regs: Avalon-MM bank queueing UDP status snapshots in a FIFO with irq, freeze and counters.
module av_snapshot_regs #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    av_snapshot_regs_if.slave          av,
    input  logic [NUM_REGS*DATA_W-1:0] reg_in,
    input  logic                       udp_data_valid,
    output logic                       av_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [NUM_REGS*DATA_W-1:0] mem [DEPTH];
    logic [LW-1:0]     wp, rp, level, level_next;
    logic [1:0]        ctrl;
    logic              overflow, dv_d;
    logic [DATA_W-1:0] overrun_cnt, snap_cnt, rd_mux;
    logic [31:0]       status;
    logic [ADDR_W-1:0] widx;
    logic              empty, full, cap, pop, push, drop, in_head, ovf_clr, orun_clr;

    always_comb begin
        level      = wp - rp;
        empty      = level == '0;
        full       = level == LW'(DEPTH);
        cap        = udp_data_valid & ~dv_d;
        pop        = av.write && av.address == ADDR_W'(2) && av.writedata[0] && !empty;
        ovf_clr    = av.write && av.address == ADDR_W'(2) && av.writedata[1];
        orun_clr   = av.write && av.address == ADDR_W'(3);
        push       = cap & ~ctrl[1] & (~full | pop);
        drop       = cap & ~ctrl[1] & full & ~pop;
        level_next = level + LW'(push) - LW'(pop);
        widx       = av.address - ADDR_W'(8);
        in_head    = av.address >= ADDR_W'(8) && int'(av.address) < 8 + NUM_REGS && !empty;
        status     = {20'd0, udp_data_valid, overflow, full, empty, 3'd0, 5'(level)};
        rd_mux     = in_head ? mem[rp[AW-1:0]][int'(widx)*DATA_W +: DATA_W] :
                     av.address == ADDR_W'(0) ? DATA_W'(ctrl) :
                     av.address == ADDR_W'(1) ? status[DATA_W-1:0] :
                     av.address == ADDR_W'(3) ? overrun_cnt :
                     av.address == ADDR_W'(4) ? snap_cnt : '0;
    end

    // Tracked through reset too, so a level held high across reset is not seen as a new edge.
    always_ff @(posedge clk) dv_d <= udp_data_valid;

    always_ff @(posedge clk) if (push && !reset) mem[wp[AW-1:0]] <= reg_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp          <= '0;
            rp          <= '0;
            ctrl        <= '0;
            overflow    <= 1'b0;
            overrun_cnt <= '0;
            snap_cnt    <= '0;
            av.readdata <= '0;
            av_irq      <= 1'b0;
        end else begin
            if (av.read) av.readdata <= rd_mux;
            if (av.write && av.address == ADDR_W'(0)) ctrl <= av.writedata[1:0];
            if (push) wp <= wp + LW'(1);
            if (pop) rp <= rp + LW'(1);
            overflow    <= drop | (overflow & ~ovf_clr);
            overrun_cnt <= orun_clr ? DATA_W'(drop) :
                           (drop && ~&overrun_cnt) ? overrun_cnt + DATA_W'(1) : overrun_cnt;
            snap_cnt    <= (push && ~&snap_cnt) ? snap_cnt + DATA_W'(1) : snap_cnt;
            av_irq      <= ctrl[0] & (level_next != '0);
        end
    end
endmodule

// File: tb/tb_av_snapshot_regs.sv
// tb_av_snapshot_regs: directed table, corner sequences and random traffic against a queue-based model.
module tb_av_snapshot_regs;
    logic         clk = 1'b0;
    logic         reset, udv, av_irq;
    logic [255:0] reg_in;
    int           checks = 0, fails = 0;

    av_snapshot_regs_if #(.ADDR_W(5), .DATA_W(32)) bus();

    av_snapshot_regs #(.NUM_REGS(8), .DATA_W(32), .DEPTH(4), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .av(bus), .reg_in(reg_in),
        .udp_data_valid(udv), .av_irq(av_irq)
    );

    always #5 clk = ~clk;

    logic [255:0] q[$];
    logic [1:0]   m_ctrl;
    logic         m_ovf, m_dv, m_irq, u_cur;
    logic [31:0]  m_orun, m_snap, m_rd;
    logic [255:0] rv_cur;

    typedef struct packed {
        logic        u;
        int          k;
        logic        r;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } tv_t;
    tv_t tv [0:18];

    function automatic logic [255:0] mk(input int k);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(256 * k + i);
        return v;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a, input logic u);
        int ai = int'(a);
        int n  = q.size();
        if (ai >= 8 && ai < 16) return n > 0 ? q[0][(ai-8)*32 +: 32] : 32'd0;
        case (ai)
            0: return {30'd0, m_ctrl};
            1: return {20'd0, u, m_ovf, n == 4, n == 0, 3'd0, 5'(n)};
            3: return m_orun;
            4: return m_snap;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic u, input logic r, input logic w,
                        input logic [4:0] a, input logic [31:0] d, input logic [255:0] rv);
        logic edge_s, pop_s, en_old, frz_old;
        reset = rs; udv = u; bus.read = r; bus.write = w; bus.address = a;
        bus.writedata = d; reg_in = rv; u_cur = u; rv_cur = rv;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ctrl = 0; m_ovf = 0; m_orun = 0; m_snap = 0; m_rd = 0; m_irq = 0;
            m_dv = u;
        end else begin
            if (r) m_rd = mread(a, u);
            edge_s  = u & ~m_dv;
            m_dv    = u;
            pop_s   = w && a == 2 && d[0] && q.size() > 0;
            en_old  = m_ctrl[0];
            frz_old = m_ctrl[1];
            if (w && a == 0) m_ctrl = d[1:0];
            if (w && a == 2 && d[1]) m_ovf = 0;
            if (w && a == 3) m_orun = 0;
            if (pop_s) void'(q.pop_front());
            if (edge_s && !frz_old) begin
                if (q.size() < 4) begin
                    q.push_back(rv);
                    if (m_snap != 32'hFFFF_FFFF) m_snap++;
                end else begin
                    m_ovf = 1;
                    if (m_orun != 32'hFFFF_FFFF) m_orun++;
                end
            end
            m_irq = en_old && q.size() > 0;
        end
        #1;
        chk("model_readdata", bus.readdata, m_rd);
        chk("model_irq", {31'd0, av_irq}, {31'd0, m_irq});
    endtask

    task automatic rd(input logic [4:0] a, input string n, input logic [31:0] exp);
        step(0, u_cur, 1, 0, a, 0, rv_cur);
        chk(n, bus.readdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(0, u_cur, 0, 1, a, d, rv_cur);
    endtask

    task automatic pulse(input int k);
        step(0, 1, 0, 0, 0, 0, mk(k));
        step(0, 0, 0, 0, 0, 0, mk(k));
    endtask

    initial begin
        tv = '{
            '{1'b0, 0, 1'b0, 1'b1, 5'd0, 32'd1, 32'h000, 1'b0},
            '{1'b1, 1, 1'b0, 1'b0, 5'd0, 32'd0, 32'h000, 1'b1},
            '{1'b0, 0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h000, 1'b1},
            '{1'b1, 2, 1'b0, 1'b0, 5'd0, 32'd0, 32'h000, 1'b1},
            '{1'b0, 0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h000, 1'b1},
            '{1'b1, 3, 1'b0, 1'b0, 5'd0, 32'd0, 32'h000, 1'b1},
            '{1'b0, 0, 1'b1, 1'b0, 5'd1, 32'd0, 32'h003, 1'b1},
            '{1'b0, 0, 1'b1, 1'b0, 5'd8, 32'd0, 32'h100, 1'b1},
            '{1'b0, 0, 1'b1, 1'b0, 5'd9, 32'd0, 32'h101, 1'b1},
            '{1'b0, 0, 1'b1, 1'b0, 5'd4, 32'd0, 32'h003, 1'b1},
            '{1'b0, 0, 1'b0, 1'b1, 5'd2, 32'd1, 32'h000, 1'b1},
            '{1'b0, 0, 1'b1, 1'b0, 5'd8, 32'd0, 32'h200, 1'b1},
            '{1'b0, 0, 1'b0, 1'b1, 5'd2, 32'd1, 32'h000, 1'b1},
            '{1'b0, 0, 1'b1, 1'b0, 5'd8, 32'd0, 32'h300, 1'b1},
            '{1'b0, 0, 1'b0, 1'b1, 5'd2, 32'd1, 32'h000, 1'b0},
            '{1'b0, 0, 1'b1, 1'b0, 5'd1, 32'd0, 32'h100, 1'b0},
            '{1'b0, 0, 1'b1, 1'b0, 5'd8, 32'd0, 32'h000, 1'b0},
            '{1'b0, 0, 1'b1, 1'b0, 5'd0, 32'd0, 32'h001, 1'b0},
            '{1'b0, 0, 1'b1, 1'b0, 5'd7, 32'd0, 32'h000, 1'b0}
        };

        step(1, 0, 0, 0, 0, 0, '0);
        step(1, 0, 1, 0, 1, 0, '0);
        chk("reset_readdata", bus.readdata, 0);
        chk("reset_irq", {31'd0, av_irq}, 0);
        rd(1, "reset_status", 32'h100);
        rd(4, "reset_snap", 0);
        rd(3, "reset_overrun", 0);
        rd(0, "reset_control", 0);

        foreach (tv[i]) begin
            step(0, tv[i].u, tv[i].r, tv[i].w, tv[i].a, tv[i].d, mk(tv[i].k));
            if (tv[i].r) chk($sformatf("tbl_rd_%0d", i), bus.readdata, tv[i].exp_rd);
            chk($sformatf("tbl_irq_%0d", i), {31'd0, av_irq}, {31'd0, tv[i].exp_irq});
        end

        step(1, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) pulse(10 + i);
        rd(1, "ovf_status", 32'h604);
        rd(3, "ovf_overrun", 2);
        rd(4, "ovf_snap", 4);
        wr(2, 2);
        rd(1, "ovf_cleared", 32'h204);
        wr(3, 32'h1234);
        rd(3, "overrun_cleared", 0);

        step(0, 1, 0, 1, 2, 1, mk(20));
        step(0, 0, 0, 0, 0, 0, mk(20));
        rd(1, "poppush_status", 32'h204);
        rd(3, "poppush_overrun", 0);
        rd(8, "poppush_head", 32'hB00);
        for (int i = 0; i < 3; i++) wr(2, 1);
        rd(8, "poppush_tail", 32'h1400);
        rd(9, "poppush_tail_w1", 32'h1401);

        wr(0, 2);
        pulse(40);
        pulse(41);
        rd(1, "frz_status", 32'h001);
        rd(4, "frz_snap", 5);
        rd(3, "frz_overrun", 0);
        wr(2, 1);
        rd(1, "frz_pop", 32'h100);
        wr(0, 0);
        pulse(21);
        rd(1, "unfrz_status", 32'h001);
        rd(4, "unfrz_snap", 6);

        step(0, 1, 0, 0, 0, 0, mk(22));
        step(1, 1, 1, 0, 8, 0, mk(22));
        chk("rst_inflight_rd", bus.readdata, 0);
        step(0, 1, 0, 0, 0, 0, mk(23));
        step(0, 1, 0, 0, 0, 0, mk(23));
        rd(1, "rst_held_status", 32'h900);
        step(0, 0, 0, 0, 0, 0, mk(23));
        pulse(30);
        rd(1, "rst_recap_status", 32'h001);
        rd(8, "rst_recap_head", 32'h1E00);
        rd(4, "rst_recap_snap", 1);

        for (int i = 0; i < 600; i++) begin
            logic rs, u, r, w;
            logic [4:0] a;
            logic [31:0] d;
            rs = $urandom_range(0, 99) == 0;
            u  = ($urandom_range(0, 2) == 0) ? ~u_cur : u_cur;
            r  = $urandom_range(0, 1) == 1;
            w  = $urandom_range(0, 2) == 0;
            a  = w ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 20));
            d  = $urandom;
            step(rs, u, r, w, a, d, {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
